// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared widths, the JALR ImmSrc code and a clog2 helper for
//                the address adder arbiter.
//  Revision    : 1.0
// ============================================================================
package adder_arb_pkg;

    localparam int XLEN = 32;
    localparam int IMMSRC_W = 3;
    localparam logic [IMMSRC_W-1:0] IMM_JALR = 3'b000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_adder.sv
`default_nettype none
// ============================================================================
//  Module      : Adder
//  Description : 32-bit address adder; clears bit 0 of the result for JALR.
//  Revision    : 1.0
// ============================================================================
module Adder
    import adder_arb_pkg::*;
(
    input  logic [XLEN-1:0]     Input_A,
    input  logic [XLEN-1:0]     Input_B,
    input  logic [IMMSRC_W-1:0] ImmSrc,
    output logic [XLEN-1:0]     Output_A
);

    logic [XLEN-1:0] w_raw_sum;

    // Carry out is intentionally dropped: address arithmetic wraps silently.
    assign w_raw_sum = Input_A + Input_B;

    always_comb begin
        Output_A = w_raw_sum;
        if (ImmSrc == IMM_JALR) begin
            Output_A[0] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin (optionally requester-0 priority) sharing of one
//                address adder, with a registered valid/ready response.
//  Revision    : 1.0
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDW   = 2,
    parameter bit PRIO0 = 1'b0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*XLEN-1:0]     req_a,
    input  logic [NREQ*XLEN-1:0]     req_b,
    input  logic [NREQ*IMMSRC_W-1:0] req_immsrc,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDW-1:0]           resp_id,
    output logic [XLEN-1:0]          resp_sum
);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("adder_arbiter: NREQ must be within 2..8");
        end
        if (IDW < clog2(NREQ)) begin : g_bad_idw
            $error("adder_arbiter: IDW too narrow for NREQ");
        end
    endgenerate

    logic                r_resp_valid;
    logic [IDW-1:0]      r_resp_id;
    logic [XLEN-1:0]     r_resp_sum;
    logic [IDW-1:0]      r_rr_ptr;

    logic [IDW-1:0]      w_grant;
    logic [IDW-1:0]      w_ptr_next;
    logic                w_hit_upper;
    logic                w_accept;
    logic [NREQ-1:0]     w_ready;
    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_b;
    logic [IMMSRC_W-1:0] w_immsrc;
    logic [XLEN-1:0]     w_sum;

    // First valid index at or above the pointer wins; otherwise wrap to the
    // lowest valid index. Descending scans leave the lowest match standing.
    always_comb begin
        w_grant     = '0;
        w_hit_upper = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_grant     = IDW'(i);
                w_hit_upper = 1'b1;
            end
        end
        if (!w_hit_upper) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    w_grant = IDW'(i);
                end
            end
        end
        if (PRIO0 && req_valid[0]) begin
            w_grant = '0;
        end
    end

    assign w_accept   = (!r_resp_valid || resp_ready) && (|req_valid);
    assign w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    always_comb begin
        w_ready  = '0;
        w_a      = '0;
        w_b      = '0;
        w_immsrc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_ready[i] = w_accept;
                w_a        = req_a[i*XLEN +: XLEN];
                w_b        = req_b[i*XLEN +: XLEN];
                w_immsrc   = req_immsrc[i*IMMSRC_W +: IMMSRC_W];
            end
        end
    end

    // Handshake is suppressed for the whole reset pulse, not just at edges.
    assign req_ready = rst ? '0 : w_ready;

    Adder u_adder (
        .Input_A  (w_a),
        .Input_B  (w_b),
        .ImmSrc   (w_immsrc),
        .Output_A (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
            r_rr_ptr     <= '0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_grant;
            r_resp_sum   <= w_sum;
            r_rr_ptr     <= w_ptr_next;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter (PRIO0=0 and PRIO0=1).
//  Revision    : 1.0
// ============================================================================
module tb_adder_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*3-1:0] req_immsrc;
    logic              resp_ready;

    logic [NREQ-1:0]   rdy0, rdy1;
    logic              v0, v1;
    logic [IDW-1:0]    id0, id1;
    logic [31:0]       s0, s1;

    int errors = 0;
    int checks = 0;

    // Reference state: index 0 models PRIO0=0, index 1 models PRIO0=1.
    bit          m_valid [2];
    int          m_id    [2];
    logic [31:0] m_sum   [2];
    int          m_ptr   [2];

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .PRIO0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_a(req_a), .req_b(req_b), .req_immsrc(req_immsrc),
        .resp_valid(v0), .resp_ready(resp_ready), .resp_id(id0), .resp_sum(s0)
    );

    adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .PRIO0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_b(req_b), .req_immsrc(req_immsrc),
        .resp_valid(v1), .resp_ready(resp_ready), .resp_id(id1), .resp_sum(s1)
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_id[k]    = 0;
            m_sum[k]   = '0;
            m_ptr[k]   = 0;
        end
    endfunction

    function automatic int model_grant(int k);
        logic [NREQ-1:0] v;
        v = req_valid;
        if (k == 1 && v[0]) return 0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = (m_ptr[k] + off) % NREQ;
            if (v[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_sum(int g);
        logic [31:0] a, b, s;
        logic [2:0]  imm;
        a   = req_a[g*32 +: 32];
        b   = req_b[g*32 +: 32];
        imm = req_immsrc[g*3 +: 3];
        s   = a + b;
        if (imm == 3'b000) s = s & 32'hFFFF_FFFE;
        return s;
    endfunction

    function automatic bit model_accept(int k);
        return (!m_valid[k] || resp_ready) && (req_valid != '0);
    endfunction

    function automatic logic [NREQ-1:0] model_ready(int k);
        logic [NREQ-1:0] r;
        r = '0;
        if (model_accept(k)) r[model_grant(k)] = 1'b1;
        return r;
    endfunction

    // One clock: the model steps on the current inputs, outputs sampled at +1.
    task automatic advance();
        bit          nv [2];
        int          nid[2];
        logic [31:0] ns [2];
        int          np [2];
        for (int k = 0; k < 2; k++) begin
            nv[k] = m_valid[k]; nid[k] = m_id[k]; ns[k] = m_sum[k]; np[k] = m_ptr[k];
            if (model_accept(k)) begin
                nv[k]  = 1'b1;
                nid[k] = model_grant(k);
                ns[k]  = model_sum(nid[k]);
                np[k]  = (nid[k] + 1) % NREQ;
            end else if (resp_ready) begin
                nv[k] = 1'b0;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = nv[k]; m_id[k] = nid[k]; m_sum[k] = ns[k]; m_ptr[k] = np[k];
        end
        #1;
    endtask

    task automatic drive_req(int i, logic [31:0] a, logic [31:0] b, logic [2:0] imm);
        req_a[i*32 +: 32]    = a;
        req_b[i*32 +: 32]    = b;
        req_immsrc[i*3 +: 3] = imm;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            drive_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        randomize_ops();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", v0); end
        checks++; if (id0 !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", id0); end
        checks++; if (s0 !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h want=0", s0); end
        checks++; if (rdy0 !== 3'b000 || rdy1 !== 3'b000) begin
            errors++; $display("FAIL reset_ready got=%b/%b want=000", rdy0, rdy1);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        model_reset();
    endtask

    task automatic test_single();
        req_valid  = 3'b010;
        resp_ready = 1'b1;
        drive_req(1, 32'h0000_1000, 32'h4, 3'b010);
        #1;
        checks++; if (rdy0 !== 3'b010) begin errors++; $display("FAIL single_ready got=%b want=010", rdy0); end
        advance();
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", v0); end
        checks++; if (id0 !== 2'd1) begin errors++; $display("FAIL single_id got=%0d want=1", id0); end
        checks++; if (s0 !== 32'h0000_1004) begin errors++; $display("FAIL single_sum got=%h want=00001004", s0); end
        req_valid = '0;
        #1;
        advance();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b want=0", v0); end
        checks++; if (s0 !== 32'h0000_1004 || id0 !== 2'd1) begin
            errors++; $display("FAIL idle_hold got=%h/%0d want=00001004/1", s0, id0);
        end
    endtask

    task automatic test_jalr();
        req_valid = 3'b001;
        drive_req(0, 32'h2001, 32'h2, 3'b000);
        #1;
        advance();
        checks++; if (s0 !== 32'h2002) begin errors++; $display("FAIL jalr_sum got=%h want=00002002", s0); end
        checks++; if (id0 !== 2'd0) begin errors++; $display("FAIL jalr_id got=%0d want=0", id0); end
    endtask

    task automatic test_wrap();
        req_valid = 3'b100;
        drive_req(2, 32'hFFFF_FFFC, 32'h8, 3'b011);
        #1;
        advance();
        checks++; if (s0 !== 32'h4) begin errors++; $display("FAIL wrap_sum got=%h want=00000004", s0); end
        checks++; if (id0 !== 2'd2) begin errors++; $display("FAIL wrap_id got=%0d want=2", id0); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            randomize_ops();
            #1;
            advance();
            checks++; if (v0 !== 1'b1 || id0 !== 2'(i % 3)) begin
                errors++; $display("FAIL rr_seq[%0d] got=v%b id%0d want=v1 id%0d", i, v0, id0, i % 3);
            end
            checks++; if (s0 !== m_sum[0]) begin
                errors++; $display("FAIL rr_sum[%0d] got=%h want=%h", i, s0, m_sum[0]);
            end
        end
    endtask

    task automatic test_prio();
        do_reset();
        req_valid  = 3'b101;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_ops();
            #1;
            checks++; if (rdy1 !== 3'b001) begin errors++; $display("FAIL prio_ready[%0d] got=%b want=001", i, rdy1); end
            advance();
            checks++; if (v1 !== 1'b1 || id1 !== 2'd0) begin
                errors++; $display("FAIL prio_id[%0d] got=v%b id%0d want=v1 id0", i, v1, id1);
            end
        end
        req_valid = 3'b100;
        #1;
        advance();
        checks++; if (v1 !== 1'b1 || id1 !== 2'd2) begin
            errors++; $display("FAIL prio_drop got=v%b id%0d want=v1 id2", v1, id1);
        end
        checks++; if (s1 !== m_sum[1]) begin errors++; $display("FAIL prio_sum got=%h want=%h", s1, m_sum[1]); end
    endtask

    task automatic test_backpressure_reset();
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        randomize_ops();
        #1;
        advance();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_ops();
            #1;
            checks++; if (rdy0 !== 3'b000) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=000", i, rdy0); end
            advance();
            checks++; if (v0 !== 1'b1 || s0 !== m_sum[0] || id0 !== 2'(m_id[0])) begin
                errors++; $display("FAIL bp_hold[%0d] got=v%b %h id%0d want=v1 %h id%0d",
                                   i, v0, s0, id0, m_sum[0], m_id[0]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%b/%b want=0/0", v0, v1);
        end
        model_reset();
        #10;
        rst        = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 3'b111;
        #1;
        checks++; if (rdy0 !== 3'b001) begin errors++; $display("FAIL post_reset_ready got=%b want=001", rdy0); end
        advance();
        checks++; if (id0 !== 2'd0 || v0 !== 1'b1) begin
            errors++; $display("FAIL post_reset_grant got=v%b id%0d want=v1 id0", v0, id0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            req_valid  = 3'($urandom_range(0, 7));
            resp_ready = ($urandom_range(0, 3) != 0);
            randomize_ops();
            #1;
            checks++; if (rdy0 !== model_ready(0) || rdy1 !== model_ready(1)) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b/%b want=%b/%b",
                                   n, rdy0, rdy1, model_ready(0), model_ready(1));
            end
            advance();
            checks++; if (v0 !== m_valid[0] || id0 !== 2'(m_id[0]) || s0 !== m_sum[0]) begin
                errors++; $display("FAIL rand_resp0[%0d] got=v%b id%0d %h want=v%b id%0d %h",
                                   n, v0, id0, s0, m_valid[0], m_id[0], m_sum[0]);
            end
            checks++; if (v1 !== m_valid[1] || id1 !== 2'(m_id[1]) || s1 !== m_sum[1]) begin
                errors++; $display("FAIL rand_resp1[%0d] got=v%b id%0d %h want=v%b id%0d %h",
                                   n, v1, id1, s1, m_valid[1], m_id[1], m_sum[1]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_immsrc = '0;
        resp_ready = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_jalr();
        test_wrap();
        test_round_robin();
        test_prio();
        test_backpressure_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
